// File: rtl/axi_inf_pkg.sv
// Shared constants and types for the AXI burst write core.
package axi_inf_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam logic [1:0] BurstIncr = 2'b01;

    localparam int unsigned Boundary4k = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StAw,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/axi_inf_burst_write_core_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst core and the interconnect.
interface axi_inf_burst_write_core_if #(
    parameter int unsigned IDSIZE = 4,
    parameter int unsigned ASIZE  = 32,
    parameter int unsigned DSIZE  = 256,
    parameter int unsigned LSIZE  = 8
);

    logic [IDSIZE-1:0]  awid;
    logic [ASIZE-1:0]   awaddr;
    logic [LSIZE-1:0]   awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               awvalid;
    logic               awready;

    logic [DSIZE-1:0]   wdata;
    logic [DSIZE/8-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;

    logic [IDSIZE-1:0]  bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_inf_len_fifo.sv
// Small synchronous FIFO carrying the beat count of each issued burst to the W path.
module axi_inf_len_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 4
) (
    input  logic             axi_aclk,
    input  logic             axi_resetn,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rptr_q];

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/axi_inf_burst_write_core.sv
// AXI4 write master: splits one request into 4 KB-safe INCR bursts with bounded outstanding AWs.
module axi_inf_burst_write_core
    import axi_inf_pkg::*;
#(
    parameter int unsigned IDSIZE     = 4,
    parameter int unsigned ID         = 0,
    parameter int unsigned ASIZE      = 32,
    parameter int unsigned DSIZE      = 256,
    parameter int unsigned LSIZE      = 8,
    parameter int unsigned TLSIZE     = 24,
    parameter int unsigned MAX_BURST  = 64,
    parameter int unsigned MAX_OUTSTD = 4
) (
    input  logic              axi_aclk,
    input  logic              axi_resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ASIZE-1:0]  req_addr,
    input  logic [TLSIZE-1:0] req_beats,
    input  logic [DSIZE-1:0]  s_wdata,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_resp,
    axi_inf_burst_write_core_if.master axi
);

    localparam int unsigned AwSizeInt = $clog2(DSIZE / 8);
    localparam int unsigned BlenW     = LSIZE + 1;
    localparam int unsigned CntW      = $clog2(MAX_OUTSTD + 1);
    localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTD);

    state_e            state_q, state_d;
    logic [ASIZE-1:0]  addr_q, addr_d;
    logic [TLSIZE-1:0] rem_q, rem_d;
    logic [BlenW-1:0]  blen_q, blen_d;
    logic [CntW-1:0]   outstd_q, outstd_d;
    logic              err_q, err_d;
    logic [1:0]        err_resp_q, err_resp_d;
    logic [BlenW-1:0]  beat_q, beat_d;

    logic              aw_fire, b_fire, b_match, b_dec;
    logic              w_fire, w_last;
    logic              fifo_full, fifo_empty;
    logic [BlenW-1:0]  head_len;
    logic [31:0]       room_4k, burst_len;

    // Requests are accepted only from IDLE; B is ignored there.
    assign req_ready = (state_q == StIdle);
    assign axi.bready = (state_q != StIdle);

    assign axi.awvalid = (state_q == StAw) && (outstd_q < MaxOut) && !fifo_full;
    assign axi.awid    = axi.awvalid ? IDSIZE'(ID) : '0;
    assign axi.awaddr  = axi.awvalid ? addr_q : '0;
    assign axi.awlen   = axi.awvalid ? LSIZE'(blen_q - 1'b1) : '0;
    assign axi.awsize  = 3'(AwSizeInt);
    assign axi.awburst = BurstIncr;

    assign aw_fire = axi.awvalid && axi.awready;
    assign b_fire  = axi.bvalid && axi.bready;
    assign b_match = b_fire && (axi.bid == IDSIZE'(ID));
    assign b_dec   = b_match && (outstd_q != '0);

    assign done     = (state_q == StDone);
    assign err      = done && err_q;
    assign err_resp = done ? err_resp_q : 2'b00;

    always_comb begin
        room_4k   = (32'(Boundary4k) - {20'd0, addr_q[11:0]}) >> AwSizeInt;
        burst_len = 32'(rem_q);
        if (burst_len > MAX_BURST) burst_len = MAX_BURST;
        if (burst_len > room_4k)   burst_len = room_4k;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        blen_d     = blen_q;
        err_d      = err_q;
        err_resp_d = err_resp_q;

        case ({aw_fire, b_dec})
            2'b10:   outstd_d = outstd_q + 1'b1;
            2'b01:   outstd_d = outstd_q - 1'b1;
            default: outstd_d = outstd_q;
        endcase

        if (b_match && (axi.bresp != RespOkay)) begin
            err_d = 1'b1;
            if (!err_q) err_resp_d = axi.bresp;
        end

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    rem_d      = req_beats;
                    err_d      = 1'b0;
                    err_resp_d = RespOkay;
                    state_d    = (req_beats == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                blen_d  = BlenW'(burst_len);
                state_d = StAw;
            end
            StAw: begin
                if (aw_fire) begin
                    addr_d  = addr_q + (ASIZE'(blen_q) << AwSizeInt);
                    rem_d   = rem_q - TLSIZE'(blen_q);
                    state_d = (rem_q == TLSIZE'(blen_q)) ? StDrain : StCalc;
                end
            end
            StDrain: begin
                // Looking at next-cycle outstanding lets done follow the final B by one cycle.
                if ((outstd_d == '0) && fifo_empty) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            blen_q     <= '0;
            outstd_q   <= '0;
            err_q      <= 1'b0;
            err_resp_q <= 2'b00;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            blen_q     <= blen_d;
            outstd_q   <= outstd_d;
            err_q      <= err_d;
            err_resp_q <= err_resp_d;
            beat_q     <= beat_d;
        end
    end

    // W path: pure pass-through gated by the presence of a pending burst length.
    assign axi.wvalid = !fifo_empty && s_wvalid;
    assign s_wready   = !fifo_empty && axi.wready;
    assign axi.wdata  = fifo_empty ? '0 : s_wdata;
    assign axi.wstrb  = '1;
    assign w_last     = !fifo_empty && (beat_q == head_len - 1'b1);
    assign axi.wlast  = w_last;
    assign w_fire     = axi.wvalid && axi.wready;

    always_comb begin
        beat_d = beat_q;
        if (w_fire) beat_d = w_last ? '0 : beat_q + 1'b1;
    end

    axi_inf_len_fifo #(
        .Width (BlenW),
        .Depth (MAX_OUTSTD)
    ) u_len_fifo (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .push       (aw_fire),
        .push_data  (blen_q),
        .pop        (w_fire && w_last),
        .head       (head_len),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_axi_inf_burst_write_core.sv
// Scoreboard bench: expected bursts and wlast positions are queued per request and popped on handshakes.
module tb_axi_inf_burst_write_core;

    localparam int unsigned IdW = 4;
    localparam int unsigned Aw  = 32;
    localparam int unsigned Dw  = 256;
    localparam int unsigned Lw  = 8;
    localparam int unsigned Tlw = 24;

    logic            clk = 1'b0;
    logic            rstn;
    logic            req_valid;
    logic            req_ready;
    logic [Aw-1:0]   req_addr;
    logic [Tlw-1:0]  req_beats;
    logic [Dw-1:0]   s_wdata;
    logic            s_wvalid;
    logic            s_wready;
    logic            done;
    logic            err;
    logic [1:0]      err_resp;

    axi_inf_burst_write_core_if #(.IDSIZE(IdW), .ASIZE(Aw), .DSIZE(Dw), .LSIZE(Lw)) bus ();

    axi_inf_burst_write_core #(
        .IDSIZE(IdW), .ID(0), .ASIZE(Aw), .DSIZE(Dw), .LSIZE(Lw),
        .TLSIZE(Tlw), .MAX_BURST(64), .MAX_OUTSTD(4)
    ) dut (
        .axi_aclk   (clk),
        .axi_resetn (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_beats  (req_beats),
        .s_wdata    (s_wdata),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .done       (done),
        .err        (err),
        .err_resp   (err_resp),
        .axi        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_aw_addr [$];
    logic [7:0]  exp_aw_len  [$];
    bit          exp_wlast   [$];
    logic [1:0]  bresp_tab   [0:15];

    bit aw_rdy_on = 1, w_rand = 0, b_enable = 1;
    bit b_hs = 0, s_hs = 0, aw_wait = 0;
    int b_pending = 0, b_issued = 0, s_idx = 0, w_seen = 0, out_model = 0;
    int aw_cnt = 0, w_cnt = 0, aw_in_xfer = 0, b_in_xfer = 0;
    int cyc = 0, acc_cyc = -1, first_awv_cyc = -1, aw5_cyc = -1;
    int first_b_cyc = -1, last_b_cyc = -1, done_cyc = -1;
    logic [31:0] aw_hold_addr;
    logic [7:0]  aw_hold_len;

    function automatic logic [Dw-1:0] pattern(int i);
        logic [31:0] w;
        w = 32'(i) ^ 32'hA5A5_0000;
        return {8{w}};
    endfunction

    // Slave and data-source model, driven just after each rising edge.
    initial begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bid = '0; bus.bresp = 2'b00;
        s_wvalid = 0; s_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.awready = aw_rdy_on;
            bus.wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wvalid    = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_hs) begin s_idx++; s_hs = 0; end
            s_wdata = pattern(s_idx);
            if (b_hs) begin
                bus.bvalid = 0;
                b_hs = 0;
            end else if (!bus.bvalid && b_pending > 0 && b_enable) begin
                bus.bvalid = 1;
                bus.bid    = '0;
                bus.bresp  = bresp_tab[b_issued];
                b_issued++;
                b_pending--;
            end
        end
    end

    // Monitor: handshakes are sampled on the falling edge and scored against the queues.
    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (bus.awvalid && first_awv_cyc < 0) first_awv_cyc = cyc;
            if (aw_wait) begin
                total++;
                if (bus.awvalid !== 1'b1 || bus.awaddr !== aw_hold_addr || bus.awlen !== aw_hold_len) begin
                    bad++;
                    $display("FAIL aw_stable: got v=%0b addr=%h len=%0d, required v=1 addr=%h len=%0d",
                             bus.awvalid, bus.awaddr, bus.awlen, aw_hold_addr, aw_hold_len);
                end
            end
            aw_wait = bus.awvalid && !bus.awready;
            aw_hold_addr = bus.awaddr;
            aw_hold_len  = bus.awlen;
            if (bus.awvalid && bus.awready) begin
                total++;
                if (exp_aw_addr.size() == 0) begin
                    bad++;
                    $display("FAIL aw_unexpected: got addr=%h len=%0d, required no AW", bus.awaddr, bus.awlen);
                end else begin
                    logic [31:0] ea;
                    logic [7:0]  el;
                    ea = exp_aw_addr.pop_front();
                    el = exp_aw_len.pop_front();
                    if (bus.awaddr !== ea || bus.awlen !== el) begin
                        bad++;
                        $display("FAIL aw_burst: got addr=%h len=%0d, required addr=%h len=%0d",
                                 bus.awaddr, bus.awlen, ea, el);
                    end
                end
                aw_cnt++;
                aw_in_xfer++;
                if (aw_in_xfer == 5) aw5_cyc = cyc;
                out_model++;
            end
            if (bus.wvalid && bus.wready) begin
                total++;
                if (exp_wlast.size() == 0) begin
                    bad++;
                    $display("FAIL w_unexpected: got a W beat with wlast=%0b, required none", bus.wlast);
                end else begin
                    bit el;
                    el = exp_wlast.pop_front();
                    if (bus.wlast !== el || bus.wdata !== pattern(w_seen)) begin
                        bad++;
                        $display("FAIL w_beat%0d: got last=%0b data=%h, required last=%0b data=%h",
                                 w_seen, bus.wlast, bus.wdata, el, pattern(w_seen));
                    end
                end
                w_seen++;
                w_cnt++;
                if (bus.wlast) b_pending++;
            end
            if (s_wvalid && s_wready) s_hs = 1;
            if (bus.bvalid && bus.bready) begin
                b_hs = 1;
                b_in_xfer++;
                if (b_in_xfer == 1) first_b_cyc = cyc;
                last_b_cyc = cyc;
                out_model--;
            end
            if (bus.awvalid && bus.awready) begin
                total++;
                if (out_model > 4) begin
                    bad++;
                    $display("FAIL outstanding: got %0d bursts in flight, required at most 4", out_model);
                end
            end
            if (done) done_cyc = cyc;
        end
    end

    task automatic do_req(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int rem, bl, room;
        a = addr;
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a[11:0])) >> 5;
            bl = (rem < 64) ? rem : 64;
            if (bl > room) bl = room;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(8'(bl - 1));
            for (int i = 0; i < bl; i++) exp_wlast.push_back(i == bl - 1);
            a = a + 32'(bl * 32);
            rem -= bl;
        end
        aw_in_xfer = 0; b_in_xfer = 0; b_issued = 0;
        first_awv_cyc = -1; aw5_cyc = -1; first_b_cyc = -1; done_cyc = -1; acc_cyc = -1;
        @(posedge clk);
        #1;
        req_valid = 1; req_addr = addr; req_beats = Tlw'(beats);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic wait_done(input string name, input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1; break; end
        end
        #1;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, required a done pulse", name, max);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_aw_addr.size() != 0 || exp_wlast.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: got %0d AW and %0d W still expected, required 0 and 0",
                     name, exp_aw_addr.size(), exp_wlast.size());
        end
    endtask

    task automatic test_reset();
        total++;
        if (req_ready !== 1'b1 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || bus.bready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy=%0b awv=%0b wv=%0b brdy=%0b, required 1 0 0 0",
                     req_ready, bus.awvalid, bus.wvalid, bus.bready);
        end
        total++;
        if (done !== 1'b0 || err !== 1'b0 || err_resp !== 2'b00 || s_wready !== 1'b0 ||
            bus.awaddr !== '0 || bus.awlen !== '0 || bus.wlast !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got done=%0b err=%0b resp=%0d swr=%0b awaddr=%h awlen=%0d wlast=%0b, required all 0",
                     done, err, err_resp, s_wready, bus.awaddr, bus.awlen, bus.wlast);
        end
    endtask

    task automatic test_single();
        int aw0, w0;
        bit ok;
        aw0 = aw_cnt; w0 = w_cnt;
        do_req(32'h1000, 64);
        wait_done("single", 500, ok);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %0b, required 0", err); end
        total++;
        if (aw_cnt - aw0 != 1 || w_cnt - w0 != 64) begin
            bad++;
            $display("FAIL single_counts: got aw=%0d w=%0d, required aw=1 w=64", aw_cnt - aw0, w_cnt - w0);
        end
        total++;
        if (done_cyc != last_b_cyc + 1) begin
            bad++;
            $display("FAIL single_done_lat: got done at %0d, required %0d", done_cyc, last_b_cyc + 1);
        end
        total++;
        if (first_awv_cyc - acc_cyc != 2) begin
            bad++;
            $display("FAIL single_aw_lat: got %0d cycles, required 2", first_awv_cyc - acc_cyc);
        end
        check_drained("single");
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got done=%0b, required 0", done); end
    endtask

    task automatic test_4k_split();
        bit ok;
        int aw0;
        aw0 = aw_cnt;
        w_rand = 1;
        do_req(32'h1F80, 10);
        wait_done("split4k", 500, ok);
        w_rand = 0;
        total++;
        if (aw_cnt - aw0 != 2) begin
            bad++;
            $display("FAIL split4k_aw: got %0d bursts, required 2", aw_cnt - aw0);
        end
        check_drained("split4k");
    endtask

    task automatic test_multi();
        bit ok;
        int aw0, w0;
        aw0 = aw_cnt; w0 = w_cnt;
        w_rand = 1;
        do_req(32'h0, 200);
        wait_done("multi", 2000, ok);
        w_rand = 0;
        total++;
        if (aw_cnt - aw0 != 4 || w_cnt - w0 != 200) begin
            bad++;
            $display("FAIL multi_counts: got aw=%0d w=%0d, required aw=4 w=200", aw_cnt - aw0, w_cnt - w0);
        end
        check_drained("multi");
    endtask

    task automatic test_outstanding();
        bit ok;
        int aw0;
        aw0 = aw_cnt;
        b_enable = 0;
        do_req(32'h0, 512);
        repeat (300) @(negedge clk);
        #1;
        total++;
        if (aw_cnt - aw0 != 4) begin
            bad++;
            $display("FAIL outstd_cap: got %0d AW with B held, required 4", aw_cnt - aw0);
        end
        b_enable = 1;
        wait_done("outstd", 2000, ok);
        total++;
        if (aw5_cyc <= first_b_cyc || first_b_cyc < 0) begin
            bad++;
            $display("FAIL outstd_fifth: got 5th AW at %0d, required after first B at %0d", aw5_cyc, first_b_cyc);
        end
        check_drained("outstd");
    endtask

    task automatic test_errors();
        bit ok;
        bresp_tab[1] = 2'b10;
        bresp_tab[3] = 2'b11;
        do_req(32'h0, 256);
        wait_done("errors", 2000, ok);
        total++;
        if (err !== 1'b1 || err_resp !== 2'b10) begin
            bad++;
            $display("FAIL errors_resp: got err=%0b resp=%0d, required err=1 resp=2", err, err_resp);
        end
        total++;
        if (b_in_xfer != 4) begin
            bad++;
            $display("FAIL errors_bcount: got %0d B, required 4", b_in_xfer);
        end
        check_drained("errors");
        for (int i = 0; i < 16; i++) bresp_tab[i] = 2'b00;
    endtask

    task automatic test_zero();
        bit ok;
        int aw0, w0;
        aw0 = aw_cnt; w0 = w_cnt;
        do_req(32'h40, 0);
        wait_done("zero", 20, ok);
        total++;
        if (done_cyc != acc_cyc + 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: got done at %0d err=%0b, required done at %0d err=0",
                     done_cyc, err, acc_cyc + 1);
        end
        total++;
        if (aw_cnt != aw0 || w_cnt != w0) begin
            bad++;
            $display("FAIL zero_activity: got aw=%0d w=%0d, required 0 and 0", aw_cnt - aw0, w_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = w_cnt;
        do_req(32'h0, 200);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (w_cnt - w0 >= 70) break;
        end
        total++;
        if (w_cnt - w0 < 70) begin
            bad++;
            $display("FAIL rstmid_reach: got %0d beats, required at least 70", w_cnt - w0);
        end
        @(posedge clk);
        #1;
        rstn = 0;
        #1;
        total++;
        if (req_ready !== 1'b1 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || bus.bready !== 1'b0 ||
            s_wready !== 1'b0 || done !== 1'b0 || err !== 1'b0 || err_resp !== 2'b00 || bus.wlast !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_out: got rdy=%0b awv=%0b wv=%0b brdy=%0b swr=%0b done=%0b err=%0b, required 1 0 0 0 0 0 0",
                     req_ready, bus.awvalid, bus.wvalid, bus.bready, s_wready, done, err);
        end
        @(posedge clk);
        #2;
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_wlast.delete();
        b_pending = 0; b_hs = 0; s_hs = 0; s_idx = 0; w_seen = 0; out_model = 0; aw_wait = 0;
        bus.bvalid = 0;
        s_wdata = pattern(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int aw0;
        aw0 = aw_cnt;
        do_req(32'h1000, 64);
        wait_done("b2b_first", 500, ok);
        do_req(32'h3F00, 16);
        wait_done("b2b_second", 500, ok);
        total++;
        if (aw_cnt - aw0 != 3) begin
            bad++;
            $display("FAIL b2b_aw: got %0d bursts, required 3", aw_cnt - aw0);
        end
        check_drained("b2b");
    endtask

    initial begin
        rstn = 0; req_valid = 0; req_addr = '0; req_beats = '0;
        for (int i = 0; i < 16; i++) bresp_tab[i] = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        #1;
        test_reset();
        test_single();
        test_4k_split();
        test_multi();
        test_outstanding();
        test_errors();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
